// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU and response handshakes seen by alu_arbiter.
// The slave modport is the arbiter; master is the surrounding pipeline and ALU.
interface alu_arbiter_if #(
  parameter int XLEN = 32
);
  logic            i_req0_valid;
  logic            o_req0_ready;
  logic [3:0]      i_req0_op;
  logic [XLEN-1:0] i_req0_a;
  logic [XLEN-1:0] i_req0_b;

  logic            i_req1_valid;
  logic            o_req1_ready;
  logic [3:0]      i_req1_op;
  logic [XLEN-1:0] i_req1_a;
  logic [XLEN-1:0] i_req1_b;

  logic            o_alu_op_valid;
  logic            i_alu_op_ready;
  logic [3:0]      o_alu_op_data;
  logic            o_alu_a_valid;
  logic [XLEN-1:0] o_alu_a_data;
  logic            o_alu_b_valid;
  logic [XLEN-1:0] o_alu_b_data;
  logic            i_alu_f_valid;
  logic [XLEN-1:0] i_alu_f_data;
  logic            i_alu_z;

  logic            o_rsp0_valid;
  logic            i_rsp0_ready;
  logic [XLEN-1:0] o_rsp0_data;
  logic            o_rsp0_zero;

  logic            o_rsp1_valid;
  logic            i_rsp1_ready;
  logic [XLEN-1:0] o_rsp1_data;
  logic            o_rsp1_zero;

  logic            o_busy;

  modport slave (
    input  i_req0_valid, i_req0_op, i_req0_a, i_req0_b,
    input  i_req1_valid, i_req1_op, i_req1_a, i_req1_b,
    input  i_alu_op_ready, i_alu_f_valid, i_alu_f_data, i_alu_z,
    input  i_rsp0_ready, i_rsp1_ready,
    output o_req0_ready, o_req1_ready,
    output o_alu_op_valid, o_alu_op_data, o_alu_a_valid, o_alu_a_data,
    output o_alu_b_valid, o_alu_b_data,
    output o_rsp0_valid, o_rsp0_data, o_rsp0_zero,
    output o_rsp1_valid, o_rsp1_data, o_rsp1_zero,
    output o_busy
  );

  modport master (
    output i_req0_valid, i_req0_op, i_req0_a, i_req0_b,
    output i_req1_valid, i_req1_op, i_req1_a, i_req1_b,
    output i_alu_op_ready, i_alu_f_valid, i_alu_f_data, i_alu_z,
    output i_rsp0_ready, i_rsp1_ready,
    input  o_req0_ready, o_req1_ready,
    input  o_alu_op_valid, o_alu_op_data, o_alu_a_valid, o_alu_a_data,
    input  o_alu_b_valid, o_alu_b_data,
    input  o_rsp0_valid, o_rsp0_data, o_rsp0_zero,
    input  o_rsp1_valid, o_rsp1_data, o_rsp1_zero,
    input  o_busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, one operation in
// flight, with a held response register per requester.
module alu_arbiter #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            last_grant;
  logic            grant_q;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;

  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_zero;
  logic [XLEN-1:0] rsp_data [2];
  logic [1:0]      rsp_ready;

  logic            elig0;
  logic            elig1;
  logic            grant0;
  logic            grant1;
  logic            done;

  // A requester holding an unconsumed response may not issue again.
  assign elig0 = bus.i_req0_valid & ~rsp_valid[0];
  assign elig1 = bus.i_req1_valid & ~rsp_valid[1];

  // On contention, the requester that was not granted last wins.
  assign grant0 = (state == IDLE) & elig0 & (~elig1 | last_grant);
  assign grant1 = (state == IDLE) & elig1 & (~elig0 | ~last_grant);

  assign done      = (state == ISSUE) & bus.i_alu_op_ready & bus.i_alu_f_valid;
  assign rsp_ready = {bus.i_rsp1_ready, bus.i_rsp0_ready};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant0 | grant1) state_nxt = ISSUE;
      ISSUE:   if (done)            state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.o_req0_ready   = grant0;
    bus.o_req1_ready   = grant1;
    bus.o_alu_op_valid = 1'b0;
    bus.o_alu_a_valid  = 1'b0;
    bus.o_alu_b_valid  = 1'b0;
    bus.o_alu_op_data  = '0;
    bus.o_alu_a_data   = '0;
    bus.o_alu_b_data   = '0;
    bus.o_busy         = 1'b0;
    if (state == ISSUE) begin
      bus.o_alu_op_valid = 1'b1;
      bus.o_alu_a_valid  = 1'b1;
      bus.o_alu_b_valid  = 1'b1;
      bus.o_alu_op_data  = op_q;
      bus.o_alu_a_data   = a_q;
      bus.o_alu_b_data   = b_q;
      bus.o_busy         = 1'b1;
    end
  end

  // NOTE: the operand/grant capture registers carry no reset; they are only
  // observed while in ISSUE, which always follows a fresh capture.
  always_ff @(posedge clk) begin
    if (grant0 | grant1) begin
      grant_q <= grant1;
      op_q    <= grant1 ? bus.i_req1_op : bus.i_req0_op;
      a_q     <= grant1 ? bus.i_req1_a  : bus.i_req0_a;
      b_q     <= grant1 ? bus.i_req1_b  : bus.i_req0_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= 1'b1;
      rsp_valid   <= '0;
      rsp_zero    <= '0;
      rsp_data[0] <= '0;
      rsp_data[1] <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (rsp_ready[n]) rsp_valid[n] <= 1'b0;
      end
      if (done) begin
        rsp_valid[grant_q] <= 1'b1;
        rsp_data[grant_q]  <= bus.i_alu_f_data;
        rsp_zero[grant_q]  <= bus.i_alu_z;
        last_grant         <= grant_q;
      end
    end
  end

  assign bus.o_rsp0_valid = rsp_valid[0];
  assign bus.o_rsp0_data  = rsp_data[0];
  assign bus.o_rsp0_zero  = rsp_zero[0];
  assign bus.o_rsp1_valid = rsp_valid[1];
  assign bus.o_rsp1_data  = rsp_data[1];
  assign bus.o_rsp1_zero  = rsp_zero[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter: the bench also plays the ALU and checks
// every cycle against a transaction-level model of the arbitration rules.
module tb_alu_arbiter;

  localparam int XLEN = 32;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;

  typedef struct packed {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.XLEN(XLEN)) bus ();
  alu_arbiter #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one in-flight operation, round-robin pointer, held responses.
  bit              m_busy;
  int              m_owner;
  op_t             m_cur;
  int              m_last;
  bit              m_rsp_v [2];
  logic [XLEN-1:0] m_rsp_d [2];
  bit              m_rsp_z [2];

  // Stimulus for the next cycle.
  bit  s_rst;
  bit  s_req_v [2];
  op_t s_req [2];
  bit  s_alu_ready, s_alu_fvalid;
  bit  s_rsp_ready [2];

  bit  got_ready [2];
  bit  drove_rsp [2];
  int  grants [$];

  function automatic logic [XLEN-1:0] alu_ref(input op_t t);
    case (t.op)
      ALU_ADD: return t.a + t.b;
      ALU_SUB: return t.a - t.b;
      ALU_AND: return t.a & t.b;
      ALU_OR:  return t.a | t.b;
      ALU_XOR: return t.a ^ t.b;
      ALU_SLL: return t.a << t.b[4:0];
      ALU_SRL: return t.a >> t.b[4:0];
      default: return '0;
    endcase
  endfunction

  function automatic op_t mk_op(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    op_t t;
    t.op = op;
    t.a  = a;
    t.b  = b;
    return t;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_last = 1;
    for (int n = 0; n < 2; n++) begin
      m_rsp_v[n] = 0;
      m_rsp_d[n] = '0;
      m_rsp_z[n] = 0;
    end
  endtask

  task automatic idle_stim();
    s_rst        = 0;
    s_alu_ready  = 1;
    s_alu_fvalid = 1;
    for (int n = 0; n < 2; n++) begin
      s_req_v[n]     = 0;
      s_req[n]       = '0;
      s_rsp_ready[n] = 0;
    end
  endtask

  task automatic drive();
    logic [XLEN-1:0] res;
    rst              = s_rst;
    bus.i_req0_valid = s_req_v[0];
    bus.i_req0_op    = s_req[0].op;
    bus.i_req0_a     = s_req[0].a;
    bus.i_req0_b     = s_req[0].b;
    bus.i_req1_valid = s_req_v[1];
    bus.i_req1_op    = s_req[1].op;
    bus.i_req1_a     = s_req[1].a;
    bus.i_req1_b     = s_req[1].b;
    // Consumers only assert ready while they actually hold a response.
    for (int n = 0; n < 2; n++) drove_rsp[n] = s_rsp_ready[n] && m_rsp_v[n];
    bus.i_rsp0_ready   = drove_rsp[0];
    bus.i_rsp1_ready   = drove_rsp[1];
    bus.i_alu_op_ready = s_alu_ready;
    bus.i_alu_f_valid  = s_alu_fvalid;
    if (m_busy) begin
      res = alu_ref(m_cur);
      bus.i_alu_f_data = res;
      bus.i_alu_z      = (res == '0);
    end else begin
      bus.i_alu_f_data = $urandom;
      bus.i_alu_z      = 1'($urandom);
    end
  endtask

  task automatic check_outputs();
    op_t exp_issue;
    exp_issue = m_busy ? m_cur : '0;
    check("busy",       bus.o_busy,         m_busy);
    check("alu_op_vld", bus.o_alu_op_valid, m_busy);
    check("alu_a_vld",  bus.o_alu_a_valid,  m_busy);
    check("alu_b_vld",  bus.o_alu_b_valid,  m_busy);
    check("alu_op",     bus.o_alu_op_data,  exp_issue.op);
    check("alu_a",      bus.o_alu_a_data,   exp_issue.a);
    check("alu_b",      bus.o_alu_b_data,   exp_issue.b);
    check("rsp0_valid", bus.o_rsp0_valid,   m_rsp_v[0]);
    check("rsp0_data",  bus.o_rsp0_data,    m_rsp_d[0]);
    check("rsp0_zero",  bus.o_rsp0_zero,    m_rsp_z[0]);
    check("rsp1_valid", bus.o_rsp1_valid,   m_rsp_v[1]);
    check("rsp1_data",  bus.o_rsp1_data,    m_rsp_d[1]);
    check("rsp1_zero",  bus.o_rsp1_zero,    m_rsp_z[1]);
  endtask

  // One clock: drive, check the grant, advance the model, check registered outputs.
  task automatic step();
    bit elig [2];
    int g;
    drive();
    #1;
    for (int n = 0; n < 2; n++) elig[n] = s_req_v[n] && !m_rsp_v[n];
    g = -1;
    if (!m_busy) begin
      if (elig[0] && elig[1]) g = 1 - m_last;
      else if (elig[0])       g = 0;
      else if (elig[1])       g = 1;
    end
    got_ready[0] = bus.o_req0_ready;
    got_ready[1] = bus.o_req1_ready;
    check("req0_ready", got_ready[0], g == 0);
    check("req1_ready", got_ready[1], g == 1);
    if (got_ready[0]) grants.push_back(0);
    if (got_ready[1]) grants.push_back(1);

    if (s_rst) begin
      model_reset();
    end else begin
      for (int n = 0; n < 2; n++) if (drove_rsp[n]) m_rsp_v[n] = 0;
      if (!m_busy) begin
        if (g >= 0) begin
          m_busy  = 1;
          m_owner = g;
          m_cur   = s_req[g];
        end
      end else if (s_alu_ready && s_alu_fvalid) begin
        m_rsp_v[m_owner] = 1;
        m_rsp_d[m_owner] = alu_ref(m_cur);
        m_rsp_z[m_owner] = (alu_ref(m_cur) == '0);
        m_last           = m_owner;
        m_busy           = 0;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain();
    idle_stim();
    s_rsp_ready[0] = 1;
    s_rsp_ready[1] = 1;
    repeat (4) step();
    idle_stim();
  endtask

  initial begin
    idle_stim();
    s_rst = 1;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    s_rst = 0;
    check_outputs();

    // Single ADD from requester 0: accept, issue next cycle, response after that.
    s_req_v[0] = 1;
    s_req[0]   = mk_op(ALU_ADD, 5, 7);
    step();
    check("s1_accept", got_ready[0], 1);
    check("s1_issue",  bus.o_alu_op_valid, 1);
    check("s1_a",      bus.o_alu_a_data, 5);
    check("s1_b",      bus.o_alu_b_data, 7);
    s_req_v[0] = 0;
    step();
    check("s1_rsp_v",  bus.o_rsp0_valid, 1);
    check("s1_rsp_d",  bus.o_rsp0_data, 12);
    check("s1_rsp_z",  bus.o_rsp0_zero, 0);
    drain();

    // Contention after reset: grants alternate starting with requester 0.
    s_rst = 1;
    step();
    idle_stim();
    grants.delete();
    s_req_v[0] = 1;
    s_req_v[1] = 1;
    s_rsp_ready[0] = 1;
    s_rsp_ready[1] = 1;
    for (int c = 0; c < 40 && grants.size() < 8; c++) begin
      s_req[0] = mk_op(ALU_ADD, XLEN'(c), 1);
      s_req[1] = mk_op(ALU_XOR, XLEN'(c), 3);
      step();
    end
    check("s2_grant_count", grants.size(), 8);
    for (int i = 0; i < grants.size() && i < 8; i++) check("s2_grant_order", grants[i], i % 2);
    drain();

    // SUB producing zero on requester 1.
    s_req_v[1] = 1;
    s_req[1]   = mk_op(ALU_SUB, 9, 9);
    step();
    s_req_v[1] = 0;
    step();
    check("s3_rsp_v", bus.o_rsp1_valid, 1);
    check("s3_rsp_d", bus.o_rsp1_data, 0);
    check("s3_rsp_z", bus.o_rsp1_zero, 1);
    drain();

    // ALU stall: operands held, no response until op_ready rises.
    s_alu_ready = 0;
    s_req_v[0]  = 1;
    s_req[0]    = mk_op(ALU_ADD, 3, 4);
    step();
    s_req_v[0]  = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("s4_hold_vld", bus.o_alu_op_valid, 1);
      check("s4_hold_a",   bus.o_alu_a_data, 3);
      check("s4_hold_b",   bus.o_alu_b_data, 4);
      check("s4_no_rsp",   bus.o_rsp0_valid, 0);
    end
    s_alu_ready = 1;
    step();
    check("s4_rsp_v", bus.o_rsp0_valid, 1);
    check("s4_rsp_d", bus.o_rsp0_data, 7);
    drain();

    // Unconsumed response blocks requester 0 while requester 1 is served.
    s_req_v[0] = 1;
    s_req[0]   = mk_op(ALU_ADD, 1, 1);
    step();
    check("s5_first", got_ready[0], 1);
    step();
    s_req_v[1] = 1;
    s_req[1]   = mk_op(ALU_OR, 8, 1);
    step();
    check("s5_blocked_c", got_ready[0], 0);
    check("s5_req1_c",    got_ready[1], 1);
    s_req_v[1]     = 0;
    s_rsp_ready[1] = 1;
    step();
    check("s5_blocked_d", got_ready[0], 0);
    s_rsp_ready[0] = 1;
    step();
    check("s5_blocked_e", got_ready[0], 0);
    s_rsp_ready[0] = 0;
    step();
    check("s5_regrant", got_ready[0], 1);
    drain();

    // Reset while in ISSUE discards the operation.
    s_alu_ready = 0;
    s_req_v[0]  = 1;
    s_req[0]    = mk_op(ALU_ADD, 10, 20);
    step();
    s_req_v[0]  = 0;
    step();
    s_rst       = 1;
    s_alu_ready = 1;
    step();
    s_rst = 0;
    check("s6_busy",  bus.o_busy, 0);
    check("s6_alu_v", bus.o_alu_op_valid, 0);
    check("s6_rsp_v", bus.o_rsp0_valid, 0);
    s_req_v[0] = 1;
    s_req_v[1] = 1;
    s_req[1]   = mk_op(ALU_SUB, 1, 2);
    step();
    check("s6_win0", got_ready[0], 1);
    check("s6_lose1", got_ready[1], 0);
    drain();

    // Random traffic with occasional resets and ALU stalls.
    for (int c = 0; c < 1500; c++) begin
      s_rst = ($urandom_range(99) == 0);
      for (int n = 0; n < 2; n++) begin
        s_req_v[n]     = !s_rst && ($urandom_range(99) < 60);
        s_req[n]       = mk_op(4'($urandom_range(15)), $urandom, $urandom);
        if ($urandom_range(3) == 0) s_req[n].b = s_req[n].a;
        s_rsp_ready[n] = ($urandom_range(1) == 1);
      end
      s_alu_ready  = ($urandom_range(3) != 0);
      s_alu_fvalid = ($urandom_range(3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ArithmeticLogicUnit between two requesters, e.g. the integer issue path and the address/branch-compare path.
- Accepts one operation at a time by round-robin, registers its operands and drives the ALU op/a/b handshake.
- Captures the result and zero flag into a per-requester response register, held until that requester consumes it.
- Sits between the decode/issue stages and the single ALU instance.

Parameters:
XLEN, 32, operand and result width; must equal the ALU's XLEN.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
i_req0_valid  input  1  requester 0 has an operation
o_req0_ready  output  1  requester 0 operation accepted this cycle
i_req0_op  input  4  requester 0 ALU opcode (pkgRiscV Alu* encoding)
i_req0_a  input  XLEN  requester 0 operand a
i_req0_b  input  XLEN  requester 0 operand b
i_req1_valid, o_req1_ready, i_req1_op, i_req1_a, i_req1_b  as above, requester 1
o_alu_op_valid  output  1  to ALU i_op_valid
i_alu_op_ready  input  1  from ALU o_op_ready
o_alu_op_data  output  4  to ALU i_op_data
o_alu_a_valid  output  1  to ALU i_a_valid
o_alu_a_data  output  XLEN  to ALU i_a_data
o_alu_b_valid  output  1  to ALU i_b_valid
o_alu_b_data  output  XLEN  to ALU i_b_data
i_alu_f_valid  input  1  from ALU o_f_valid
i_alu_f_data  input  XLEN  from ALU o_f_data
i_alu_z  input  1  from ALU o_z_valid
o_rsp0_valid  output  1  requester 0 result pending
i_rsp0_ready  input  1  requester 0 consumes result
o_rsp0_data  output  XLEN  requester 0 result
o_rsp0_zero  output  1  requester 0 zero flag
o_rsp1_valid, i_rsp1_ready, o_rsp1_data, o_rsp1_zero  as above, requester 1
o_busy  output  1  FSM not in IDLE

Behaviour:
- Reset (rst high at a clock edge):
  - FSM goes to IDLE; all outputs are 0.
  - The last-grant pointer is set to 1, so requester 0 wins first.
  - Any captured operation is discarded and produces no response.
  - Response registers are cleared, including mid-operation.
- Eligibility: requester n is eligible when i_reqn_valid=1 and o_rspn_valid=0, sampled at the start of the cycle. This enforces one outstanding operation per requester. A response consumed in a cycle does not make its requester eligible until the next cycle.
- IDLE state:
  - ALU valids are 0; op/a/b data are 0.
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the one that is not the last-grant pointer.
  - On grant: pulse o_reqn_ready=1 for that cycle only; register op, a, b and the grant index; go to ISSUE.
  - o_reqn_ready is never 1 outside IDLE and never 1 for both requesters at once.
- ISSUE state:
  - Drive o_alu_op_valid=o_alu_a_valid=o_alu_b_valid=1, with op/a/b from the registers, held stable.
  - Completion condition: i_alu_op_ready & i_alu_f_valid.
  - While the completion condition is 0, stay in ISSUE; this is an ALU stall of unbounded length.
  - When it is 1: load o_rspg_data=i_alu_f_data and o_rspg_zero=i_alu_z; set o_rspg_valid=1; set last-grant to g; go to IDLE.
- Latency and throughput:
  - Accept at cycle N; ISSUE at N+1; o_rsp valid visible at N+2 with no stall.
  - Peak throughput is one operation per 2 cycles.
- Response registers:
  - o_rspn_valid clears on the cycle i_rspn_ready=1.
  - data and zero hold their value until the next load.
  - A load and a consume on the same requester cannot coincide, because of the eligibility rule.
- o_busy=1 exactly when the FSM is in ISSUE.
- Opcode values pass through unmodified; an illegal opcode is the ALU's concern. Its result (0) is returned normally.
- No combinational path from i_req* or i_alu_* to o_alu_*. o_reqn_ready depends only on registered state and i_reqn_valid.

Test Plan:
- After reset, req0 sends AluAdd a=5 b=7 -> o_req0_ready pulses one cycle; o_alu_op_valid high the next cycle with a=5, b=7; o_rsp0_valid=1 with data=12, zero=0 two cycles after accept.
- req0 and req1 valid simultaneously after reset -> req0 granted first, req1 granted next IDLE; pointer alternates for 4 back-to-back pairs (0,1,0,1,...).
- req1 AluSub a=9 b=9 -> o_rsp1_data=0, o_rsp1_zero=1.
- i_alu_op_ready held low 3 cycles in ISSUE -> ALU outputs stable throughout, no response; response appears the cycle after op_ready rises.
- req0 response left unconsumed while req0 stays valid -> req0 not regranted; req1 is still served; req0 regranted the cycle after i_rsp0_ready=1.
- rst asserted during ISSUE -> next cycle all valids 0, no response, FSM IDLE, req0 wins the next contention.
